// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding, select decode helpers and address alignment for the APB responder
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
  localparam int ALIGN_BITS = 2;
  localparam int MAX_SLAVES = 32;
  function automatic int sel_idx(input logic [MAX_SLAVES-1:0] sel);
    int r;
    r = 0;
    for (int i = 0; i < MAX_SLAVES; i++) if (sel[i]) r = i;
    return r;
  endfunction
  function automatic logic is_onehot(input logic [MAX_SLAVES-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: one slave's word register file with async clear and combinational read-out
module apb_reg_bank #(
  parameter int DATA_W = 32,
  parameter int REGS = 8,
  parameter int IDX_W = $clog2(REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [REGS];
  logic [DATA_W-1:0] mem_d [REGS];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = wdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign rdata = mem_q[idx];
endmodule

// File: rtl/apb_multi_slave_responder.sv
// apb_multi_slave_responder: APB slave responder with per-slave register banks, wait states and error flagging
module apb_multi_slave_responder
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REGS_PER_SLAVE = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  input  logic [NUM_SLAVES-1:0] Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_W-1:0]     Paddr,
  input  logic [DATA_W-1:0]     Pwdata,
  output logic [DATA_W-1:0]     Prdata,
  output logic                  Pready,
  output logic                  Pslverr,
  output logic                  xfer_done
);
  localparam int IDX_W = $clog2(REGS_PER_SLAVE);
  localparam int SLV_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_cur;
  logic xfer_done_q, xfer_done_d;
  logic [MAX_SLAVES-1:0] sel_w;
  logic [SLV_W-1:0] slv;
  logic [IDX_W-1:0] idx;
  logic sel_any, in_access, done, err;
  logic [DATA_W-1:0] bank_rd [NUM_SLAVES];
  // The SETUP cycle that sees Penable is already the first access-phase cycle, so it counts as zero waits elapsed
  always_comb begin
    sel_w = MAX_SLAVES'(Pselx);
    sel_any = |Pselx;
    slv = SLV_W'(sel_idx(sel_w));
    idx = Paddr[IDX_W+ALIGN_BITS-1:ALIGN_BITS];
    err = !is_onehot(sel_w) || (Paddr[ALIGN_BITS-1:0] != '0) || ((Paddr >> (IDX_W + ALIGN_BITS)) != '0);
    in_access = (state_q == SETUP || state_q == ACCESS) && Penable && sel_any;
    cnt_cur = state_q == ACCESS ? cnt_q : 4'd0;
    done = in_access && cnt_cur == 4'(WAIT_STATES);
    Pready = done;
    Pslverr = done && err;
    Prdata = done && !err && !Pwrite ? bank_rd[slv] : '0;
    state_d = state_q == IDLE  ? (sel_any && !Penable ? SETUP : IDLE) :
              state_q == SETUP ? (!sel_any ? IDLE : !Penable ? SETUP : done ? IDLE : ACCESS) :
              (in_access && !done ? ACCESS : IDLE);
    cnt_d = in_access && !done ? cnt_cur + 4'd1 : 4'd0;
    xfer_done_d = done;
  end
  always_ff @(posedge Hclk or posedge Hreset)
    if (Hreset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      xfer_done_q <= xfer_done_d;
    end
  assign xfer_done = xfer_done_q;
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_bank
    apb_reg_bank #(.DATA_W(DATA_W), .REGS(REGS_PER_SLAVE), .IDX_W(IDX_W)) u_bank (
      .clk(Hclk),
      .rst(Hreset),
      .we(done && !err && Pwrite && slv == SLV_W'(i)),
      .idx(idx),
      .wdata(Pwdata),
      .rdata(bank_rd[i])
    );
  end
endmodule

// File: tb/tb_apb_multi_slave_responder.sv
// tb_apb_multi_slave_responder: zero-wait and two-wait responders driven in lockstep against a register-file model
module tb_apb_multi_slave_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] psel = '0;
  logic pen = 1'b0;
  logic pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] rdata [2];
  logic ready [2];
  logic slverr [2];
  logic xd [2];
  logic [31:0] mdl [2][3][8];
  logic pending [2];
  int errors = 0;
  int checks = 0;
  int last_len = 0;
  always #5 clk = ~clk;
  apb_multi_slave_responder #(.WAIT_STATES(0)) u_dut0 (
    .Hclk(clk), .Hreset(rst), .Pselx(psel), .Penable(pen), .Pwrite(pwrite), .Paddr(paddr),
    .Pwdata(pwdata), .Prdata(rdata[0]), .Pready(ready[0]), .Pslverr(slverr[0]), .xfer_done(xd[0])
  );
  apb_multi_slave_responder #(.WAIT_STATES(2)) u_dut2 (
    .Hclk(clk), .Hreset(rst), .Pselx(psel), .Penable(pen), .Pwrite(pwrite), .Paddr(paddr),
    .Pwdata(pwdata), .Prdata(rdata[1]), .Pready(ready[1]), .Pslverr(slverr[1]), .xfer_done(xd[1])
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic bit is_err(input logic [2:0] sel, input logic [31:0] a);
    return $countones(sel) != 1 || a[1:0] != 2'b00 || a >= 32'd32;
  endfunction
  function automatic int sidx(input logic [2:0] sel);
    return sel[0] ? 0 : sel[1] ? 1 : 2;
  endfunction
  task automatic clear_model();
    for (int w = 0; w < 2; w++) begin
      pending[w] = 1'b0;
      for (int s = 0; s < 3; s++) for (int r = 0; r < 8; r++) mdl[w][s][r] = '0;
    end
  endtask
  task automatic chk_quiet(input string tag);
    for (int w = 0; w < 2; w++) begin
      chk({tag, "_ready"}, 32'(ready[w]), 0);
      chk({tag, "_slverr"}, 32'(slverr[w]), 0);
      chk({tag, "_rdata"}, rdata[w], 0);
      chk({tag, "_xfer_done"}, 32'(xd[w]), 0);
    end
  endtask
  task automatic idle_cyc();
    psel = '0;
    pen = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("idle_xfer_done", 32'(xd[w]), 32'(pending[w]));
      chk("idle_ready", 32'(ready[w]), 0);
      pending[w] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask
  // len = number of Penable cycles driven; a responder with ws waits completes only if ws < len
  task automatic xfer(input bit wr, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] d, input int len);
    bit e;
    int ws;
    logic cmp;
    e = is_err(sel, a);
    psel = sel;
    pen = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = d;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("setup_ready", 32'(ready[w]), 0);
      chk("setup_xfer_done", 32'(xd[w]), 32'(pending[w]));
    end
    @(posedge clk);
    #1;
    pen = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        ws = 2 * w;
        cmp = k == ws;
        chk("ready", 32'(ready[w]), 32'(cmp));
        chk("slverr", 32'(slverr[w]), 32'(cmp && e));
        chk("rdata", rdata[w], (cmp && !e && !wr) ? mdl[w][sidx(sel)][a[4:2]] : 32'd0);
        chk("xfer_done", 32'(xd[w]), 32'(k == ws + 1));
      end
      @(posedge clk);
      #1;
    end
    for (int w = 0; w < 2; w++) begin
      pending[w] = (len - 1) == 2 * w;
      if (2 * w < len && !e && wr) mdl[w][sidx(sel)][a[4:2]] = d;
    end
    last_len = len;
  endtask
  initial begin
    logic [2:0] sel;
    logic [31:0] a;
    int r;
    int len;
    clear_model();
    #3;
    chk_quiet("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cyc();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 8; i++) begin
        sel = 3'b001 << s;
        xfer(1'b0, sel, 32'(i * 4), 32'd0, 3);
      end
    idle_cyc();
    xfer(1'b1, 3'b010, 32'h0C, 32'hDEADBEEF, 3);
    xfer(1'b0, 3'b010, 32'h0C, 32'd0, 3);
    xfer(1'b0, 3'b001, 32'h0C, 32'd0, 3);
    idle_cyc();
    for (int i = 0; i < 8; i++) xfer(1'b1, 3'b001, 32'(i * 4), 32'hA500_0000 + 32'(i), 1);
    for (int i = 0; i < 8; i++) xfer(1'b0, 3'b001, 32'(i * 4), 32'd0, 1);
    idle_cyc();
    xfer(1'b1, 3'b011, 32'h04, 32'h11112222, 3);
    xfer(1'b1, 3'b100, 32'h02, 32'h33334444, 3);
    xfer(1'b0, 3'b100, 32'h20, 32'd0, 3);
    xfer(1'b0, 3'b001, 32'h04, 32'd0, 3);
    xfer(1'b0, 3'b010, 32'h04, 32'd0, 3);
    xfer(1'b0, 3'b100, 32'h00, 32'd0, 3);
    idle_cyc();
    xfer(1'b1, 3'b100, 32'h10, 32'hCAFEF00D, 2);
    idle_cyc();
    xfer(1'b0, 3'b100, 32'h10, 32'd0, 3);
    idle_cyc();
    psel = 3'b001;
    pen = 1'b1;
    pwrite = 1'b1;
    paddr = 32'h0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) chk("ignored_ready", 32'(ready[w]), 0);
      @(posedge clk);
      #1;
    end
    idle_cyc();
    xfer(1'b0, 3'b001, 32'h0, 32'd0, 3);
    idle_cyc();
    psel = 3'b001;
    pen = 1'b0;
    pwrite = 1'b1;
    paddr = 32'h08;
    pwdata = 32'h12345678;
    @(posedge clk);
    #1;
    pen = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #1;
    chk("pre_reset_ready", 32'(ready[1]), 1);
    rst = 1'b1;
    #1;
    chk_quiet("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    psel = '0;
    pen = 1'b0;
    clear_model();
    idle_cyc();
    xfer(1'b0, 3'b001, 32'h08, 32'd0, 3);
    idle_cyc();
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      sel = r < 8 ? 3'b001 << $urandom_range(0, 2) : (r == 8 ? 3'b011 : 3'b111);
      r = $urandom_range(0, 11);
      a = 32'($urandom_range(0, 7) * 4);
      if (r == 10) a = a + 32'($urandom_range(1, 3));
      if (r == 11) a = a + (32'd32 << $urandom_range(0, 26));
      len = $urandom_range(1, 3);
      if (last_len != 3 || $urandom_range(0, 1) == 0) idle_cyc();
      xfer(1'($urandom_range(0, 1)), sel, a, $urandom, len);
    end
    idle_cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
